// File: rtl/wb_stage.sv
// Write-back stage: EXM/WB buffer, write-back mux, register-file write port,
// forwarding selects back into EXM, input-port synchronizer and registered output port.
module wb_stage (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic [2:0]  i_write_addr,
   input  logic [15:0] i_immediate,
   input  logic [15:0] i_memory_data,
   input  logic [15:0] i_ex_result,
   input  logic [1:0]  i_wb_selector,
   input  logic        i_write_back,
   input  logic        i_output_port,
   input  logic [15:0] i_output_data,
   input  logic [15:0] i_in_port,
   input  logic [2:0]  i_ex_rs,
   input  logic [2:0]  i_ex_rt,
   input  logic        i_ex_src1_used,
   input  logic        i_ex_src2_used,
   output logic        o_rf_write_en,
   output logic [2:0]  o_rf_write_addr,
   output logic [15:0] o_rf_write_data,
   output logic [15:0] o_data_wb,
   output logic        o_data1_forward,
   output logic        o_data2_forward,
   output logic [15:0] o_out_port,
   output logic        o_out_port_valid
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned SEL_W  = 2;

   localparam logic [SEL_W-1:0] SEL_EX  = 2'b00;
   localparam logic [SEL_W-1:0] SEL_MEM = 2'b01;
   localparam logic [SEL_W-1:0] SEL_IMM = 2'b10;

   typedef struct packed {
      logic [ADDR_W-1:0] write_addr;
      logic [DATA_W-1:0] immediate;
      logic [DATA_W-1:0] memory_data;
      logic [DATA_W-1:0] ex_result;
      logic [SEL_W-1:0]  wb_selector;
      logic              write_back;
   } wb_buf_t;

   wb_buf_t           buf_q;
   wb_buf_t           buf_d;
   logic [DATA_W-1:0] sync1_q;
   logic [DATA_W-1:0] sync2_q;
   logic [DATA_W-1:0] wb_data;
   logic              out_accept;

   // Buffer next value: flush beats stall, stall beats load.
   always_comb begin
      buf_d = buf_q;
      if (i_flush) begin
         buf_d = '0;
      end else if (!i_stall) begin
         buf_d.write_addr  = i_write_addr;
         buf_d.immediate   = i_immediate;
         buf_d.memory_data = i_memory_data;
         buf_d.ex_result   = i_ex_result;
         buf_d.wb_selector = i_wb_selector;
         buf_d.write_back  = i_write_back;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         buf_q <= '0;
      end else begin
         buf_q <= buf_d;
      end
   end

   // Two-flop synchronizer on the asynchronous input port; ignores stall.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= i_in_port;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      wb_data = sync2_q;
      case (buf_q.wb_selector)
         SEL_EX:  wb_data = buf_q.ex_result;
         SEL_MEM: wb_data = buf_q.memory_data;
         SEL_IMM: wb_data = buf_q.immediate;
         default: wb_data = sync2_q;
      endcase
   end

   assign o_rf_write_en   = buf_q.write_back;
   assign o_rf_write_addr = buf_q.write_addr;
   assign o_rf_write_data = wb_data;
   assign o_data_wb       = wb_data;

   // Register 0 is forwarded like any other register.
   assign o_data1_forward = buf_q.write_back & (buf_q.write_addr == i_ex_rs) & i_ex_src1_used;
   assign o_data2_forward = buf_q.write_back & (buf_q.write_addr == i_ex_rt) & i_ex_src2_used;

   // An OUT is taken only on the edge where it leaves EXM, so a stalled OUT strobes once.
   assign out_accept = i_output_port & ~i_stall & ~i_flush;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_out_port       <= '0;
         o_out_port_valid <= 1'b0;
      end else begin
         o_out_port_valid <= out_accept;
         if (out_accept) begin
            o_out_port <= i_output_data;
         end
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand sequences, random vs. model.
module tb_wb_stage;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_stall, i_flush;
   logic [2:0]  i_write_addr;
   logic [15:0] i_immediate, i_memory_data, i_ex_result;
   logic [1:0]  i_wb_selector;
   logic        i_write_back, i_output_port;
   logic [15:0] i_output_data, i_in_port;
   logic [2:0]  i_ex_rs, i_ex_rt;
   logic        i_ex_src1_used, i_ex_src2_used;
   logic        o_rf_write_en;
   logic [2:0]  o_rf_write_addr;
   logic [15:0] o_rf_write_data, o_data_wb;
   logic        o_data1_forward, o_data2_forward;
   logic [15:0] o_out_port;
   logic        o_out_port_valid;

   int checks = 0;
   int errors = 0;

   wb_stage dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
      .i_write_addr(i_write_addr), .i_immediate(i_immediate), .i_memory_data(i_memory_data),
      .i_ex_result(i_ex_result), .i_wb_selector(i_wb_selector), .i_write_back(i_write_back),
      .i_output_port(i_output_port), .i_output_data(i_output_data), .i_in_port(i_in_port),
      .i_ex_rs(i_ex_rs), .i_ex_rt(i_ex_rt), .i_ex_src1_used(i_ex_src1_used),
      .i_ex_src2_used(i_ex_src2_used), .o_rf_write_en(o_rf_write_en),
      .o_rf_write_addr(o_rf_write_addr), .o_rf_write_data(o_rf_write_data),
      .o_data_wb(o_data_wb), .o_data1_forward(o_data1_forward),
      .o_data2_forward(o_data2_forward), .o_out_port(o_out_port),
      .o_out_port_valid(o_out_port_valid)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        stall, flush, wb;
      logic [1:0]  sel;
      logic [2:0]  addr;
      logic [15:0] ex, mem, imm;
      logic        op;
      logic [15:0] odata;
      logic [2:0]  rs, rt;
      logic        u1, u2;
      logic        e_en;
      logic [2:0]  e_addr;
      logic [15:0] e_data;
      logic        e_f1, e_f2;
      logic [15:0] e_out;
      logic        e_valid;
   } vec_t;

   vec_t vecs[10];

   typedef struct {
      logic [2:0]  addr;
      logic [15:0] ex, mem, imm;
      logic [1:0]  sel;
      logic        wb;
   } instr_t;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_stall = 0; i_flush = 0; i_write_addr = 0; i_immediate = 0; i_memory_data = 0;
      i_ex_result = 0; i_wb_selector = 0; i_write_back = 0; i_output_port = 0;
      i_output_data = 0; i_ex_rs = 0; i_ex_rt = 0; i_ex_src1_used = 0; i_ex_src2_used = 0;
   endtask

   task automatic do_reset();
      #2 i_reset = 1'b0;
      #1;
      @(negedge i_clk);
      i_reset = 1'b1;
   endtask

   // Model state for the random phase.
   instr_t      m_buf;
   logic [15:0] m_hist[$];
   logic [15:0] m_out;
   logic        m_valid;

   function automatic logic [15:0] m_synced();
      if (m_hist.size() < 2) return 16'h0000;
      return m_hist[m_hist.size()-2];
   endfunction

   function automatic logic [15:0] m_data();
      case (m_buf.sel)
         2'd0:    return m_buf.ex;
         2'd1:    return m_buf.mem;
         2'd2:    return m_buf.imm;
         default: return m_synced();
      endcase
   endfunction

   initial begin
      clear_inputs();
      i_in_port = 16'h0000;
      i_reset   = 1'b0;
      i_ex_src1_used = 1; i_ex_src2_used = 1;
      #12;
      chk("reset_en", 16'(o_rf_write_en), 16'h0);
      chk("reset_addr", 16'(o_rf_write_addr), 16'h0);
      chk("reset_data", o_rf_write_data, 16'h0);
      chk("reset_f1", 16'(o_data1_forward), 16'h0);
      chk("reset_f2", 16'(o_data2_forward), 16'h0);
      chk("reset_out", o_out_port, 16'h0);
      chk("reset_valid", 16'(o_out_port_valid), 16'h0);
      @(negedge i_clk);
      i_reset = 1'b1;

      // stall flush wb sel addr ex mem imm op odata rs rt u1 u2 | en addr data f1 f2 out valid
      vecs[0] = '{0,0,1,2'd0,3'd5,16'h1234,16'h0,16'h0,0,16'h0,3'd5,3'd2,1,1, 1,3'd5,16'h1234,1,0,16'h0,0};
      vecs[1] = '{0,0,1,2'd1,3'd3,16'h0,16'hABCD,16'h0,0,16'h0,3'd3,3'd3,1,0, 1,3'd3,16'hABCD,1,0,16'h0,0};
      vecs[2] = '{0,0,0,2'd2,3'd3,16'h0,16'h0,16'h0042,0,16'h0,3'd3,3'd3,1,1, 0,3'd3,16'h0042,0,0,16'h0,0};
      vecs[3] = '{1,0,1,2'd0,3'd7,16'hFFFF,16'h0,16'h0,0,16'h0,3'd3,3'd7,1,1, 0,3'd3,16'h0042,0,0,16'h0,0};
      vecs[4] = '{1,1,1,2'd0,3'd6,16'h9999,16'h0,16'h0,0,16'h0,3'd0,3'd0,1,1, 0,3'd0,16'h0,0,0,16'h0,0};
      vecs[5] = '{0,0,1,2'd0,3'd0,16'h5555,16'h0,16'h0,0,16'h0,3'd0,3'd0,1,1, 1,3'd0,16'h5555,1,1,16'h0,0};
      vecs[6] = '{0,0,1,2'd0,3'd2,16'h0,16'h0,16'h0,1,16'h00A5,3'd2,3'd2,0,1, 1,3'd2,16'h0,0,1,16'h00A5,1};
      vecs[7] = '{0,0,0,2'd0,3'd1,16'h0,16'h0,16'h0,0,16'h0,3'd1,3'd4,1,1, 0,3'd1,16'h0,0,0,16'h00A5,0};
      vecs[8] = '{1,0,1,2'd0,3'd6,16'h0,16'h0,16'h0,1,16'h0BAD,3'd1,3'd1,1,1, 0,3'd1,16'h0,0,0,16'h00A5,0};
      vecs[9] = '{0,1,1,2'd0,3'd6,16'h0,16'h0,16'h0,1,16'h0BAD,3'd0,3'd0,1,1, 0,3'd0,16'h0,0,0,16'h00A5,0};

      for (int k = 0; k < 10; k++) begin
         i_stall = vecs[k].stall; i_flush = vecs[k].flush; i_write_back = vecs[k].wb;
         i_wb_selector = vecs[k].sel; i_write_addr = vecs[k].addr; i_ex_result = vecs[k].ex;
         i_memory_data = vecs[k].mem; i_immediate = vecs[k].imm; i_output_port = vecs[k].op;
         i_output_data = vecs[k].odata; i_ex_rs = vecs[k].rs; i_ex_rt = vecs[k].rt;
         i_ex_src1_used = vecs[k].u1; i_ex_src2_used = vecs[k].u2;
         tick();
         chk($sformatf("vec%0d_en", k), 16'(o_rf_write_en), 16'(vecs[k].e_en));
         chk($sformatf("vec%0d_addr", k), 16'(o_rf_write_addr), 16'(vecs[k].e_addr));
         chk($sformatf("vec%0d_data", k), o_rf_write_data, vecs[k].e_data);
         chk($sformatf("vec%0d_data_wb", k), o_data_wb, vecs[k].e_data);
         chk($sformatf("vec%0d_f1", k), 16'(o_data1_forward), 16'(vecs[k].e_f1));
         chk($sformatf("vec%0d_f2", k), 16'(o_data2_forward), 16'(vecs[k].e_f2));
         chk($sformatf("vec%0d_out", k), o_out_port, vecs[k].e_out);
         chk($sformatf("vec%0d_valid", k), 16'(o_out_port_valid), 16'(vecs[k].e_valid));
      end

      // Input-port synchronizer: one edge shows the old value, two edges the new one.
      clear_inputs();
      i_in_port = 16'h1111;
      repeat (3) tick();
      i_in_port = 16'hBEEF; i_wb_selector = 2'd3; i_write_back = 1; i_write_addr = 3'd6;
      tick();
      chk("sync_1edge", o_rf_write_data, 16'h1111);
      tick();
      chk("sync_2edge", o_rf_write_data, 16'hBEEF);
      chk("sync_data_wb", o_data_wb, 16'hBEEF);

      // OUT followed by a 3-cycle stall with a different OUT waiting in EXM.
      clear_inputs();
      i_output_port = 1; i_output_data = 16'h00A5; i_write_back = 1; i_write_addr = 3'd4;
      i_ex_result = 16'h0777;
      tick();
      chk("out_val", o_out_port, 16'h00A5);
      chk("out_strobe", 16'(o_out_port_valid), 16'h1);
      i_stall = 1; i_output_data = 16'h5A5A; i_write_addr = 3'd1; i_ex_result = 16'h0000;
      i_ex_rs = 3'd4; i_ex_src1_used = 1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("stall%0d_valid", c), 16'(o_out_port_valid), 16'h0);
         chk($sformatf("stall%0d_out", c), o_out_port, 16'h00A5);
         chk($sformatf("stall%0d_addr", c), 16'(o_rf_write_addr), 16'h4);
         chk($sformatf("stall%0d_data", c), o_rf_write_data, 16'h0777);
         chk($sformatf("stall%0d_f1", c), 16'(o_data1_forward), 16'h1);
      end
      i_stall = 0;
      tick();
      chk("stalled_out_val", o_out_port, 16'h5A5A);
      chk("stalled_out_strobe", 16'(o_out_port_valid), 16'h1);
      i_output_port = 0;
      tick();
      chk("strobe_drop", 16'(o_out_port_valid), 16'h0);
      chk("out_hold", o_out_port, 16'h5A5A);

      // Asynchronous reset between edges while write enable and strobe are high.
      i_output_port = 1; i_output_data = 16'h3C3C; i_write_back = 1;
      tick();
      chk("pre_rst_en", 16'(o_rf_write_en), 16'h1);
      chk("pre_rst_valid", 16'(o_out_port_valid), 16'h1);
      #2 i_reset = 1'b0;
      #1;
      chk("arst_en", 16'(o_rf_write_en), 16'h0);
      chk("arst_valid", 16'(o_out_port_valid), 16'h0);
      chk("arst_out", o_out_port, 16'h0);
      chk("arst_f1", 16'(o_data1_forward), 16'h0);
      @(negedge i_clk);
      i_reset = 1'b1;

      // Random phase against the model; reset first so the model starts known.
      clear_inputs();
      i_in_port = 16'h0;
      do_reset();
      m_buf = '{3'd0, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0};
      m_hist.delete();
      m_out = 16'h0;
      m_valid = 1'b0;
      for (int n = 0; n < 400; n++) begin
         i_stall = ($urandom % 5) == 0;
         i_flush = ($urandom % 7) == 0;
         i_write_addr = 3'($urandom);
         i_immediate = 16'($urandom);
         i_memory_data = 16'($urandom);
         i_ex_result = 16'($urandom);
         i_wb_selector = 2'($urandom);
         i_write_back = 1'($urandom);
         i_output_port = ($urandom % 3) == 0;
         i_output_data = 16'($urandom);
         i_in_port = 16'($urandom);
         i_ex_rs = 3'($urandom);
         i_ex_rt = 3'($urandom);
         i_ex_src1_used = 1'($urandom);
         i_ex_src2_used = 1'($urandom);
         @(posedge i_clk);
         m_hist.push_back(i_in_port);
         if (m_hist.size() > 4) void'(m_hist.pop_front());
         m_valid = i_output_port && !i_stall && !i_flush;
         if (m_valid) m_out = i_output_data;
         if (i_flush) m_buf = '{3'd0, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0};
         else if (!i_stall)
            m_buf = '{i_write_addr, i_ex_result, i_memory_data, i_immediate, i_wb_selector, i_write_back};
         #1;
         chk("rnd_en", 16'(o_rf_write_en), 16'(m_buf.wb));
         chk("rnd_addr", 16'(o_rf_write_addr), 16'(m_buf.addr));
         chk("rnd_data", o_rf_write_data, m_data());
         chk("rnd_data_wb", o_data_wb, m_data());
         chk("rnd_f1", 16'(o_data1_forward), 16'(m_buf.wb && m_buf.addr == i_ex_rs && i_ex_src1_used));
         chk("rnd_f2", 16'(o_data2_forward), 16'(m_buf.wb && m_buf.addr == i_ex_rt && i_ex_src2_used));
         chk("rnd_out", o_out_port, m_out);
         chk("rnd_valid", 16'(o_out_port_valid), 16'(m_valid));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
